// File: rtl/pkt_ingress_writer.sv
// Ingress writer for the packet buffer FIFO: writes beats, commits kept packets,
// and rewinds the FIFO write pointer on filter drops, overflow or protocol aborts.
module pkt_ingress_writer #(
   parameter int ADDR_WIDTH = 11,
   parameter int W_DATA     = 8,
   parameter int W_CNT      = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [W_DATA-1:0]     ingress_data,
   input  logic                  ingress_valid,
   input  logic                  ingress_sop,
   input  logic                  ingress_eop,
   input  logic                  ingress_drop,
   output logic                  ingress_ready,
   output logic [W_DATA:0]       fifo_wdata,
   output logic                  fifo_wen,
   input  logic                  fifo_full,
   input  logic [ADDR_WIDTH:0]   fifo_wptr,
   output logic                  fifo_wrst,
   output logic [ADDR_WIDTH:0]   fifo_rst_wptr,
   output logic [ADDR_WIDTH:0]   commit_wptr,
   output logic                  commit_valid,
   output logic [W_CNT-1:0]      pkt_count,
   output logic [W_CNT-1:0]      drop_count,
   output logic [W_CNT-1:0]      abort_count
);

   localparam int PW = ADDR_WIDTH + 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RECV    = 2'd1,
      DISCARD = 2'd2,
      REWIND  = 2'd3
   } state_t;

   state_t          state_r, state_nxt_s;
   logic [PW-1:0]   start_ptr_r;
   logic [PW-1:0]   commit_wptr_r;
   logic            commit_valid_r;
   logic            pending_r, pending_nxt_s;
   logic [W_CNT-1:0] pkt_count_r, drop_count_r, abort_count_r;

   logic            ready_s, beat_s, pkt_beat_s, wen_s;
   logic            load_start_s, commit_s, inc_drop_s, inc_abort_s;

   assign ready_s = (state_r != REWIND);
   assign beat_s  = ingress_valid && ready_s;

   // Next-state and per-beat decisions; a sop beat in IDLE is handled like a RECV beat
   always_comb begin
      state_nxt_s   = state_r;
      pending_nxt_s = pending_r;
      pkt_beat_s    = 1'b0;
      wen_s         = 1'b0;
      load_start_s  = 1'b0;
      commit_s      = 1'b0;
      inc_drop_s    = 1'b0;
      inc_abort_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (beat_s && ingress_sop) begin
               load_start_s = 1'b1;
               pkt_beat_s   = 1'b1;
            end else begin
               pkt_beat_s   = 1'b0;
            end
         end
         RECV: begin
            if (beat_s) begin
               pkt_beat_s = 1'b1;
            end else begin
               pkt_beat_s = 1'b0;
            end
         end
         DISCARD: begin
            if (beat_s && ingress_eop) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DISCARD;
            end
         end
         REWIND: begin
            if (pending_r) begin
               state_nxt_s = DISCARD;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase

      if (pkt_beat_s) begin
         if (fifo_full) begin
            inc_abort_s   = 1'b1;
            state_nxt_s   = REWIND;
            pending_nxt_s = !ingress_eop;
         end else if ((state_r == RECV) && ingress_sop) begin
            // A new sop while a packet is open: abort it and swallow the newcomer
            inc_abort_s   = 1'b1;
            state_nxt_s   = REWIND;
            pending_nxt_s = 1'b1;
         end else if (ingress_eop && ingress_drop) begin
            inc_drop_s    = 1'b1;
            state_nxt_s   = REWIND;
            pending_nxt_s = 1'b0;
         end else if (ingress_eop) begin
            wen_s         = 1'b1;
            commit_s      = 1'b1;
            state_nxt_s   = IDLE;
         end else begin
            wen_s         = 1'b1;
            state_nxt_s   = RECV;
         end
      end else begin
         wen_s = 1'b0;
      end
   end

   // State, pointers and statistics
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r        <= IDLE;
         pending_r      <= 1'b0;
         start_ptr_r    <= {PW{1'b0}};
         commit_wptr_r  <= {PW{1'b0}};
         commit_valid_r <= 1'b0;
         pkt_count_r    <= {W_CNT{1'b0}};
         drop_count_r   <= {W_CNT{1'b0}};
         abort_count_r  <= {W_CNT{1'b0}};
      end else begin
         state_r        <= state_nxt_s;
         pending_r      <= pending_nxt_s;
         commit_valid_r <= commit_s;
         if (load_start_s) start_ptr_r <= fifo_wptr;
         // fifo_wptr has not yet absorbed the eop write, hence the +1
         if (commit_s) begin
            commit_wptr_r <= fifo_wptr + {{(PW-1){1'b0}}, 1'b1};
            pkt_count_r   <= pkt_count_r + {{(W_CNT-1){1'b0}}, 1'b1};
         end
         if (inc_drop_s)  drop_count_r  <= drop_count_r + {{(W_CNT-1){1'b0}}, 1'b1};
         if (inc_abort_s) abort_count_r <= abort_count_r + {{(W_CNT-1){1'b0}}, 1'b1};
      end
   end

   assign ingress_ready = ready_s;
   assign fifo_wdata    = {ingress_eop, ingress_data};
   assign fifo_wen      = wen_s;
   assign fifo_wrst     = (state_r == REWIND);
   assign fifo_rst_wptr = start_ptr_r;
   assign commit_wptr   = commit_wptr_r;
   assign commit_valid  = commit_valid_r;
   assign pkt_count     = pkt_count_r;
   assign drop_count    = drop_count_r;
   assign abort_count   = abort_count_r;

endmodule

// File: tb/tb_pkt_ingress_writer.sv
// Scoreboard bench for pkt_ingress_writer with a behavioural FIFO write-pointer model.
module tb_pkt_ingress_writer;

   localparam int AW = 11;
   localparam int WD = 8;
   localparam int WC = 32;
   localparam int PW = AW + 1;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [WD-1:0]  ingress_data = 8'h00;
   logic           ingress_valid = 1'b0;
   logic           ingress_sop = 1'b0;
   logic           ingress_eop = 1'b0;
   logic           ingress_drop = 1'b0;
   logic           ingress_ready;
   logic [WD:0]    fifo_wdata;
   logic           fifo_wen;
   logic           fifo_full = 1'b0;
   logic [PW-1:0]  fifo_wptr;
   logic           fifo_wrst;
   logic [PW-1:0]  fifo_rst_wptr;
   logic [PW-1:0]  commit_wptr;
   logic           commit_valid;
   logic [WC-1:0]  pkt_count, drop_count, abort_count;

   logic           preset_en = 1'b0;
   logic [PW-1:0]  preset_val = 12'h000;

   logic [WD:0]    exp_wr_q[$];
   logic [PW-1:0]  exp_commit_q[$];
   logic [PW-1:0]  exp_rw_q[$];

   int total = 0;
   int passed = 0;

   pkt_ingress_writer #(.ADDR_WIDTH(AW), .W_DATA(WD), .W_CNT(WC)) dut (
      .clk(clk), .reset(reset),
      .ingress_data(ingress_data), .ingress_valid(ingress_valid),
      .ingress_sop(ingress_sop), .ingress_eop(ingress_eop),
      .ingress_drop(ingress_drop), .ingress_ready(ingress_ready),
      .fifo_wdata(fifo_wdata), .fifo_wen(fifo_wen), .fifo_full(fifo_full),
      .fifo_wptr(fifo_wptr), .fifo_wrst(fifo_wrst), .fifo_rst_wptr(fifo_rst_wptr),
      .commit_wptr(commit_wptr), .commit_valid(commit_valid),
      .pkt_count(pkt_count), .drop_count(drop_count), .abort_count(abort_count)
   );

   always #5 clk = ~clk;

   // FIFO write pointer: advances on writes, reloads on rewind, shares reset
   always @(posedge clk or posedge reset) begin
      if (reset)          fifo_wptr <= 12'h000;
      else if (preset_en) fifo_wptr <= preset_val;
      else if (fifo_wrst) fifo_wptr <= fifo_rst_wptr;
      else if (fifo_wen)  fifo_wptr <= fifo_wptr + 12'h001;
   end

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
   endfunction

   function automatic void unexpected(input string name, input logic [31:0] act);
      total++;
      $display("FAIL %s: got 0x%0h, required no event", name, act);
   endfunction

   // Monitor: pops the scoreboard whenever the DUT presents a write, commit or rewind
   always @(negedge clk) begin
      if (!reset) begin
         if (fifo_wen) begin
            if (exp_wr_q.size() == 0) unexpected("write", 32'(fifo_wdata));
            else chk("write_data", 32'(fifo_wdata), 32'(exp_wr_q.pop_front()));
         end
         if (commit_valid) begin
            if (exp_commit_q.size() == 0) unexpected("commit", 32'(commit_wptr));
            else chk("commit_wptr", 32'(commit_wptr), 32'(exp_commit_q.pop_front()));
         end
         if (fifo_wrst) begin
            chk("rewind_ready", 32'(ingress_ready), 32'd0);
            chk("rewind_wen", 32'(fifo_wen), 32'd0);
            if (exp_rw_q.size() == 0) unexpected("rewind", 32'(fifo_rst_wptr));
            else chk("rst_wptr", 32'(fifo_rst_wptr), 32'(exp_rw_q.pop_front()));
         end
      end
   end

   task automatic send(input logic [7:0] d, input logic s, input logic e,
                       input logic dr, input logic f);
      logic acc;
      int n;
      ingress_data = d; ingress_valid = 1'b1; ingress_sop = s;
      ingress_eop = e; ingress_drop = dr; fifo_full = f;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 16) begin
         @(negedge clk);
         acc = ingress_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) begin
         total++;
         $display("FAIL beat_accept: data 0x%0h not accepted, required within 16 cycles", d);
      end
      ingress_valid = 1'b0; ingress_sop = 1'b0; ingress_eop = 1'b0;
      ingress_drop = 1'b0; fifo_full = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_counts(input string tag, input int p, input int d, input int a, input int c);
      chk({tag, "_pkt"}, pkt_count, 32'(p));
      chk({tag, "_drop"}, drop_count, 32'(d));
      chk({tag, "_abort"}, abort_count, 32'(a));
      chk({tag, "_commit_wptr"}, 32'(commit_wptr), 32'(c));
   endtask

   initial begin
      // Reset state
      idle(2);
      @(negedge clk);
      chk("rst_ready", 32'(ingress_ready), 32'd1);
      chk("rst_wen", 32'(fifo_wen), 32'd0);
      chk("rst_wrst", 32'(fifo_wrst), 32'd0);
      chk("rst_commit_valid", 32'(commit_valid), 32'd0);
      chk_counts("rst", 0, 0, 0, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      idle(1);

      // Kept 4-beat packet
      exp_wr_q.push_back(9'h011); exp_wr_q.push_back(9'h012);
      exp_wr_q.push_back(9'h013); exp_wr_q.push_back(9'h114);
      exp_commit_q.push_back(12'h004);
      send(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
      send(8'h12, 1'b0, 1'b0, 1'b0, 1'b0);
      send(8'h13, 1'b0, 1'b0, 1'b0, 1'b0);
      send(8'h14, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(3);
      chk_counts("keep", 1, 0, 0, 4);

      // Filter drop on eop
      exp_wr_q.push_back(9'h021); exp_wr_q.push_back(9'h022);
      exp_rw_q.push_back(12'h004);
      send(8'h21, 1'b1, 1'b0, 1'b0, 1'b0);
      send(8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
      send(8'h23, 1'b0, 1'b1, 1'b1, 1'b0);
      idle(3);
      chk_counts("drop", 1, 1, 0, 4);
      chk("drop_wptr", 32'(fifo_wptr), 32'h4);

      // Overflow on beat 3 of 10
      exp_wr_q.push_back(9'h031); exp_wr_q.push_back(9'h032);
      exp_rw_q.push_back(12'h004);
      send(8'h31, 1'b1, 1'b0, 1'b0, 1'b0);
      send(8'h32, 1'b0, 1'b0, 1'b0, 1'b0);
      send(8'h33, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 4; i <= 10; i++) send(8'(8'h30 + i), 1'b0, (i == 10), 1'b0, 1'b0);
      idle(3);
      chk_counts("ovf", 1, 1, 1, 4);
      chk("ovf_wptr", 32'(fifo_wptr), 32'h4);

      // Eight back-to-back single-beat packets
      for (int i = 1; i <= 8; i++) begin
         exp_wr_q.push_back(9'(9'h140 + i));
         exp_commit_q.push_back(12'(4 + i));
      end
      for (int i = 1; i <= 8; i++) send(8'(8'h40 + i), 1'b1, 1'b1, 1'b0, 1'b0);
      idle(3);
      chk_counts("b2b", 9, 1, 1, 12);

      // sop arriving mid-packet
      exp_wr_q.push_back(9'h051);
      exp_rw_q.push_back(12'h00C);
      send(8'h51, 1'b1, 1'b0, 1'b0, 1'b0);
      send(8'h61, 1'b1, 1'b0, 1'b0, 1'b0);
      send(8'h62, 1'b0, 1'b0, 1'b0, 1'b0);
      send(8'h63, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(3);
      chk_counts("midsop", 9, 1, 2, 12);
      chk("midsop_wptr", 32'(fifo_wptr), 32'hC);

      // Pointer wrap from 0xFFE
      preset_val = 12'hFFE; preset_en = 1'b1;
      idle(1);
      preset_en = 1'b0;
      exp_wr_q.push_back(9'h071); exp_wr_q.push_back(9'h072);
      exp_wr_q.push_back(9'h073); exp_wr_q.push_back(9'h174);
      exp_commit_q.push_back(12'h002);
      send(8'h71, 1'b1, 1'b0, 1'b0, 1'b0);
      send(8'h72, 1'b0, 1'b0, 1'b0, 1'b0);
      send(8'h73, 1'b0, 1'b0, 1'b0, 1'b0);
      send(8'h74, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(3);
      chk_counts("wrap", 10, 1, 2, 2);

      // Reset during beat 2 of the next packet
      exp_wr_q.push_back(9'h081);
      send(8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
      ingress_data = 8'h82; ingress_valid = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      chk_counts("midrst", 0, 0, 0, 0);
      chk("midrst_commit_valid", 32'(commit_valid), 32'd0);
      chk("midrst_wrst", 32'(fifo_wrst), 32'd0);
      chk("midrst_wen", 32'(fifo_wen), 32'd0);
      ingress_valid = 1'b0;
      idle(2);
      reset = 1'b0;
      send(8'h82, 1'b0, 1'b1, 1'b0, 1'b0);
      exp_wr_q.push_back(9'h191);
      exp_commit_q.push_back(12'h001);
      send(8'h91, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(3);
      chk_counts("post_rst", 1, 0, 0, 1);

      chk("left_writes", 32'(exp_wr_q.size()), 32'd0);
      chk("left_commits", 32'(exp_commit_q.size()), 32'd0);
      chk("left_rewinds", 32'(exp_rw_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/pkt_ingress_writer.md
Name: pkt_ingress_writer

Overview:
- Upstream writer stage for the packet buffer FIFO.
- Accepts a byte-stream packet interface, writes each beat into the FIFO, and receives the filter verdict on the eop beat.
- Kept packets are committed by publishing an updated commit pointer to the downstream reader.
- Dropped or overflowed packets are erased by rewinding the FIFO write pointer to the packet start.

Parameters:
ADDR_WIDTH, 11, FIFO address width; pointers are ADDR_WIDTH+1 bits.
W_DATA, 8, ingress data width; FIFO word is W_DATA+1 bits (bit W_DATA = eop marker).
W_CNT, 32, statistics counter width.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
ingress_data  in  W_DATA  beat data
ingress_valid  in  1  beat valid
ingress_sop  in  1  first beat of packet
ingress_eop  in  1  last beat of packet
ingress_drop  in  1  filter verdict; sampled only on the eop beat
ingress_ready  out  1  beat accepted when valid&&ready
fifo_wdata  out  W_DATA+1  {eop, data} to FIFO
fifo_wen  out  1  FIFO write enable
fifo_full  in  1  FIFO full
fifo_wptr  in  ADDR_WIDTH+1  FIFO current write pointer
fifo_wrst  out  1  FIFO write-pointer reset strobe
fifo_rst_wptr  out  ADDR_WIDTH+1  rewind target
commit_wptr  out  ADDR_WIDTH+1  pointer just past the last committed packet
commit_valid  out  1  one-cycle pulse when commit_wptr updates
pkt_count  out  W_CNT  committed packets
drop_count  out  W_CNT  filter-dropped packets
abort_count  out  W_CNT  overflow or protocol aborts

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; start_ptr, commit_wptr, all counters = 0; commit_valid=0.
  - Combinational outputs resolve to fifo_wen=0, fifo_wrst=0, ingress_ready=1.
- State machine: IDLE, RECV, DISCARD, REWIND. Definitions: beat = ingress_valid && ingress_ready; wr_ok = beat && !fifo_full.
- ingress_ready=1 in IDLE, RECV and DISCARD; ingress_ready=0 in REWIND. This guarantees fifo_wen and fifo_wrst are never high together.
- fifo_wdata = {ingress_eop, ingress_data}, combinational.
- fifo_rst_wptr = start_ptr.
- fifo_wrst = (state==REWIND), from the state register.
- IDLE:
  - Beat without sop: accepted and ignored; no write, no count.
  - sop beat: start_ptr <= fifo_wptr. Then handle as a RECV beat, with the eop rules applied in the same cycle (a single-beat packet is legal).
- RECV, beat with fifo_full=1:
  - No write; abort_count++; next state REWIND.
  - Remember discard_pending = !ingress_eop.
- RECV, sop beat (missing eop):
  - No write; abort_count++; REWIND; discard_pending=1.
  - The new packet is discarded through its eop.
- RECV, eop beat with ingress_drop=1:
  - No write; drop_count++; REWIND; discard_pending=0.
- RECV, eop beat with ingress_drop=0 and !fifo_full:
  - fifo_wen=1.
  - commit_wptr <= fifo_wptr+1 (modulo 2^(ADDR_WIDTH+1)); commit_valid <= 1 on the next cycle.
  - pkt_count++; next state IDLE.
- RECV, other beats: fifo_wen = wr_ok.
- REWIND:
  - Lasts exactly 1 cycle; the FIFO loads start_ptr.
  - Next state is DISCARD if discard_pending, else IDLE.
- DISCARD:
  - Accepts beats, no writes.
  - On an eop beat, next state is IDLE.
  - sop beats are ignored.
- Pointer timing: fifo_wptr lags a write by one cycle, so fifo_wptr in the eop cycle equals the count before that beat; hence +1. start_ptr sampled in IDLE is always settled, because the preceding REWIND or commit write has landed.
- Wrap-around: all pointer arithmetic is ADDR_WIDTH+1 bits and wraps naturally.
- Counters wrap at 2^W_CNT.
- commit_wptr never moves backwards or on drop/abort.
- Reset mid-packet: immediate return to IDLE with all counters cleared. The FIFO shares reset, so no partial data survives.

Test Plan:
- Reset; 4-beat packet 0x11..0x14, drop=0 -> 4 writes, fifo_wdata[8]=1 only on 0x14, commit_wptr 0->4, one commit_valid pulse, pkt_count=1.
- Next 3-beat packet, drop=1 on eop -> 2 writes; REWIND cycle with fifo_wrst=1, fifo_rst_wptr=4, ingress_ready=0; drop_count=1; commit_wptr stays 4.
- 10-beat packet from wptr=4, fifo_full forced high on beat 3 -> beats 1-2 written, rewind to 4, beats 4-10 accepted with no writes, abort_count=1, IDLE after eop.
- 8 back-to-back single-beat (sop&eop) packets, drop=0, valid every cycle -> 8 writes, commit_wptr increments by 1 per cycle to 12, pkt_count=9.
- sop arrives mid-packet at beat 2 -> abort_count++, rewind to start_ptr, second packet discarded through its eop, no commit.
- Start at fifo_wptr=0xFFE (ADDR_WIDTH=11), 4-beat kept packet -> commit_wptr=0x002 (wrapped). Assert reset during beat 2 of the following packet -> all counters and commit_wptr=0 immediately, state IDLE.
